// File: rtl/amba_master_bridge_if.sv
// -----------------------------------------------------------------------------
// amba_master_bridge_if
// AXI-lite style AMBA channel bundle between the CPU-side master bridge and the
// memory / LED / SW slave.
//   master modport : drives AW*, W*, BREADY, AR*, RREADY; samples the rest
//   slave  modport : the mirror image
// Channel widths:
//   AWADDR/ARADDR ADDR_W, WDATA/RDATA DATA_W, WSTRB 4,
//   AWPROT 3, ARPROT 1, BRESP 1, RRESP 2
// -----------------------------------------------------------------------------
interface amba_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [3:0]        WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic              BVALID;
    logic              BRESP;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    logic              RVALID;
    logic [1:0]        RRESP;
    logic [DATA_W-1:0] RDATA;
    logic              RREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID, input AWREADY,
        output WDATA, WSTRB, WVALID, input WREADY,
        input BVALID, BRESP, output BREADY,
        output ARADDR, ARPROT, ARVALID, input ARREADY,
        input RVALID, RRESP, RDATA, output RREADY
    );

    modport slave (
        input AWADDR, AWPROT, AWVALID, output AWREADY,
        input WDATA, WSTRB, WVALID, output WREADY,
        output BVALID, BRESP, input BREADY,
        input ARADDR, ARPROT, ARVALID, output ARREADY,
        output RVALID, RRESP, RDATA, input RREADY
    );
endinterface

// File: rtl/amba_master_bridge.sv
// -----------------------------------------------------------------------------
// amba_master_bridge
// Converts a single-outstanding CPU load/store request into AXI-lite style
// AMBA read/write channel transactions, returning load data and a one-cycle
// completion pulse (with error flag) to the CPU.
//
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   req/we/addr/wdata/be: CPU request (sampled only while idle)
//   busy                : high while a bus transaction is in flight
//   done/err            : one-cycle completion pulse, err valid with done
//   rdata               : load data, held until the next read completes
//   bus                 : AMBA channel bundle (master modport)
//
// Optional feature (macro AMBA_TIMEOUT_EN): a watchdog aborts a transaction
// with done=1/err=1 after TIMEOUT_CYCLES cycles without handshake progress.
// Without the macro the bridge waits on the slave indefinitely.
// -----------------------------------------------------------------------------
module amba_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [3:0]           be,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [DATA_W-1:0]    rdata,
    amba_master_bridge_if.master bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_AW_W = 3'd1;
    localparam logic [2:0] ST_WR_B    = 3'd2;
    localparam logic [2:0] ST_RD_AR   = 3'd3;
    localparam logic [2:0] ST_RD_R    = 3'd4;

    logic [2:0]        state_r,   state_s;
    logic              awvalid_r, awvalid_s;
    logic              wvalid_r,  wvalid_s;
    logic              bready_r,  bready_s;
    logic              arvalid_r, arvalid_s;
    logic              rready_r,  rready_s;
    logic              done_r,    done_s;
    logic              err_r,     err_s;
    logic              busy_r;
    logic [ADDR_W-1:0] awaddr_r,  awaddr_s;
    logic [ADDR_W-1:0] araddr_r,  araddr_s;
    logic [DATA_W-1:0] wdata_r,   wdata_s;
    logic [DATA_W-1:0] rdata_r,   rdata_s;
    logic [3:0]        wstrb_r,   wstrb_s;
    logic              aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic              tmo_hit_s;

    // Channel handshakes as seen at the coming clock edge.
    always_comb begin
        aw_hs_s = awvalid_r & bus.AWREADY;
        w_hs_s  = wvalid_r  & bus.WREADY;
        b_hs_s  = bready_r  & bus.BVALID;
        ar_hs_s = arvalid_r & bus.ARREADY;
        r_hs_s  = rready_r  & bus.RVALID;
    end

`ifdef AMBA_TIMEOUT_EN
    localparam int TMO_W_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMO_W     = (TMO_W_RAW > 8) ? TMO_W_RAW : 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             progress_s;

    // Abort once the counter would reach TIMEOUT_CYCLES with no progress this cycle.
    always_comb begin
        progress_s = aw_hs_s | w_hs_s | b_hs_s | ar_hs_s | r_hs_s;
        tmo_hit_s  = (state_r != ST_IDLE) && !progress_s && (tmo_cnt_r == TMO_LAST);
    end

    // Watchdog: cleared on any state change or handshake, counts while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_s != state_r) || progress_s) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r != ST_IDLE) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    // No watchdog: the parameter is kept so both builds share one instantiation.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end

    // Watchdog absent; the abort path is never taken.
    always_comb begin
        tmo_hit_s = 1'b0;
    end
`endif

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_s   = state_r;
        awvalid_s = awvalid_r;
        wvalid_s  = wvalid_r;
        bready_s  = bready_r;
        arvalid_s = arvalid_r;
        rready_s  = rready_r;
        awaddr_s  = awaddr_r;
        araddr_s  = araddr_r;
        wdata_s   = wdata_r;
        wstrb_s   = wstrb_r;
        rdata_s   = rdata_r;
        done_s    = 1'b0;
        err_s     = 1'b0;

        if (tmo_hit_s) begin
            state_s   = ST_IDLE;
            awvalid_s = 1'b0;
            wvalid_s  = 1'b0;
            bready_s  = 1'b0;
            arvalid_s = 1'b0;
            rready_s  = 1'b0;
            done_s    = 1'b1;
            err_s     = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        if (!we) begin
                            araddr_s  = addr;
                            arvalid_s = 1'b1;
                            state_s   = ST_RD_AR;
                        end else if (be != 4'h0) begin
                            awaddr_s  = addr;
                            wdata_s   = wdata;
                            wstrb_s   = be;
                            awvalid_s = 1'b1;
                            wvalid_s  = 1'b1;
                            state_s   = ST_WR_AW_W;
                        end else begin
                            // Store with no enabled bytes completes without touching the bus.
                            done_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WR_AW_W: begin
                    // AW and W retire independently, in any order or together.
                    awvalid_s = awvalid_r & ~aw_hs_s;
                    wvalid_s  = wvalid_r  & ~w_hs_s;
                    if (!awvalid_s && !wvalid_s) begin
                        bready_s = 1'b1;
                        state_s  = ST_WR_B;
                    end else begin
                        state_s = ST_WR_AW_W;
                    end
                end
                ST_WR_B: begin
                    if (b_hs_s) begin
                        bready_s = 1'b0;
                        done_s   = 1'b1;
                        err_s    = bus.BRESP;
                        state_s  = ST_IDLE;
                    end else begin
                        state_s = ST_WR_B;
                    end
                end
                ST_RD_AR: begin
                    if (ar_hs_s) begin
                        arvalid_s = 1'b0;
                        rready_s  = 1'b1;
                        state_s   = ST_RD_R;
                    end else begin
                        state_s = ST_RD_AR;
                    end
                end
                ST_RD_R: begin
                    if (r_hs_s) begin
                        // Data is captured even on an error response.
                        rdata_s  = bus.RDATA;
                        rready_s = 1'b0;
                        done_s   = 1'b1;
                        err_s    = |bus.RRESP;
                        state_s  = ST_IDLE;
                    end else begin
                        state_s = ST_RD_R;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    awvalid_s = 1'b0;
                    wvalid_s  = 1'b0;
                    bready_s  = 1'b0;
                    arvalid_s = 1'b0;
                    rready_s  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset drops every strobe immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            busy_r    <= 1'b0;
            awaddr_r  <= {ADDR_W{1'b0}};
            araddr_r  <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
            wstrb_r   <= 4'h0;
            rdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_s;
            awvalid_r <= awvalid_s;
            wvalid_r  <= wvalid_s;
            bready_r  <= bready_s;
            arvalid_r <= arvalid_s;
            rready_r  <= rready_s;
            done_r    <= done_s;
            err_r     <= err_s;
            busy_r    <= (state_s != ST_IDLE);
            awaddr_r  <= awaddr_s;
            araddr_r  <= araddr_s;
            wdata_r   <= wdata_s;
            wstrb_r   <= wstrb_s;
            rdata_r   <= rdata_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign rdata       = rdata_r;
    assign bus.AWADDR  = awaddr_r;
    assign bus.AWPROT  = 3'b000;
    assign bus.AWVALID = awvalid_r;
    assign bus.WDATA   = wdata_r;
    assign bus.WSTRB   = wstrb_r;
    assign bus.WVALID  = wvalid_r;
    assign bus.BREADY  = bready_r;
    assign bus.ARADDR  = araddr_r;
    assign bus.ARPROT  = 1'b0;
    assign bus.ARVALID = arvalid_r;
    assign bus.RREADY  = rready_r;

endmodule

// File: tb/tb_amba_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_amba_master_bridge
// Randomised and directed stimulus for amba_master_bridge. A behavioural slave
// answers each channel after a configurable delay. Every request pushes its
// expected completion into a scoreboard queue; an independent monitor pops it
// on each done pulse and also watches the bus for handshake contents and VALID
// stability. Timing-critical cases are checked cycle by cycle by the stimulus.
// -----------------------------------------------------------------------------
module tb_amba_master_bridge;

    localparam int TMO = 8;

    typedef struct {
        bit          err;
        bit          rd;
        logic [31:0] rdata;
        int          n_aw;
        int          n_w;
        int          n_ar;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        busy, done, err;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        sb_q[$];
    logic [31:0] mdl_rdata;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    bit          bus_idle_exp;

    int          cfg_aw_dly, cfg_w_dly, cfg_b_dly, cfg_ar_dly, cfg_r_dly;
    logic        cfg_bresp;
    logic [1:0]  cfg_rresp;
    logic [31:0] cfg_rdata;

    amba_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    amba_master_bridge #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .be(be), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .bus(bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural slave: each channel answers after cfg_*_dly cycles of waiting.
    initial begin : slave
        int aw_c, w_c, b_c, ar_c, r_c;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        bus_if.AWREADY = 1'b0; bus_if.WREADY = 1'b0; bus_if.BVALID = 1'b0;
        bus_if.BRESP = 1'b0; bus_if.ARREADY = 1'b0; bus_if.RVALID = 1'b0;
        bus_if.RRESP = 2'b00; bus_if.RDATA = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_if.AWVALID) begin bus_if.AWREADY = (aw_c == cfg_aw_dly); aw_c++; end
            else begin bus_if.AWREADY = 1'b0; aw_c = 0; end
            if (bus_if.WVALID) begin bus_if.WREADY = (w_c == cfg_w_dly); w_c++; end
            else begin bus_if.WREADY = 1'b0; w_c = 0; end
            if (bus_if.ARVALID) begin bus_if.ARREADY = (ar_c == cfg_ar_dly); ar_c++; end
            else begin bus_if.ARREADY = 1'b0; ar_c = 0; end
            if (bus_if.BREADY && b_c == cfg_b_dly) begin
                bus_if.BVALID = 1'b1; bus_if.BRESP = cfg_bresp; b_c++;
            end else begin
                bus_if.BVALID = 1'b0; bus_if.BRESP = 1'($urandom);
                b_c = bus_if.BREADY ? b_c + 1 : 0;
            end
            if (bus_if.RREADY && r_c == cfg_r_dly) begin
                bus_if.RVALID = 1'b1; bus_if.RRESP = cfg_rresp; bus_if.RDATA = cfg_rdata; r_c++;
            end else begin
                bus_if.RVALID = 1'b0; bus_if.RRESP = 2'($urandom); bus_if.RDATA = $urandom;
                r_c = bus_if.RREADY ? r_c + 1 : 0;
            end
        end
    end

    // Monitor: scoreboard pops on done, bus handshake contents, VALID stability.
    initial begin : monitor
        exp_t        e;
        int          aw_n, w_n, ar_n;
        logic        p_awv, p_wv, p_arv;
        logic [31:0] p_awaddr, p_wdata, p_araddr;
        logic [3:0]  p_wstrb;
        aw_n = 0; w_n = 0; ar_n = 0;
        p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
        p_awaddr = 32'h0; p_wdata = 32'h0; p_araddr = 32'h0; p_wstrb = 4'h0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                aw_n = 0; w_n = 0; ar_n = 0;
                p_awv = 1'b0; p_wv = 1'b0; p_arv = 1'b0;
            end else begin
                if (p_awv) begin
                    chk("awvalid_stable", bus_if.AWVALID, 1'b1);
                    chk("awaddr_stable", bus_if.AWADDR, p_awaddr);
                end
                if (p_wv) begin
                    chk("wvalid_stable", bus_if.WVALID, 1'b1);
                    chk("wdata_stable", bus_if.WDATA, p_wdata);
                    chk("wstrb_stable", bus_if.WSTRB, p_wstrb);
                end
                if (p_arv) begin
                    chk("arvalid_stable", bus_if.ARVALID, 1'b1);
                    chk("araddr_stable", bus_if.ARADDR, p_araddr);
                end
                p_awv = bus_if.AWVALID & ~bus_if.AWREADY; p_awaddr = bus_if.AWADDR;
                p_wv  = bus_if.WVALID  & ~bus_if.WREADY;  p_wdata = bus_if.WDATA; p_wstrb = bus_if.WSTRB;
                p_arv = bus_if.ARVALID & ~bus_if.ARREADY; p_araddr = bus_if.ARADDR;
                if (bus_if.AWVALID && bus_if.AWREADY) begin
                    aw_n++;
                    chk("awaddr", bus_if.AWADDR, cur_addr);
                    chk("awprot", 32'(bus_if.AWPROT), 32'h0);
                end
                if (bus_if.WVALID && bus_if.WREADY) begin
                    w_n++;
                    chk("wdata", bus_if.WDATA, cur_wdata);
                    chk("wstrb", 32'(bus_if.WSTRB), 32'(cur_be));
                end
                if (bus_if.ARVALID && bus_if.ARREADY) begin
                    ar_n++;
                    chk("araddr", bus_if.ARADDR, cur_addr);
                    chk("arprot", 32'(bus_if.ARPROT), 32'h0);
                end
                if (bus_idle_exp) begin
                    chk("no_bus_activity", {29'h0, bus_if.AWVALID, bus_if.WVALID, bus_if.ARVALID}, 32'h0);
                end
                if (done) begin
                    if (sb_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected no completion at %0t", $time);
                    end else begin
                        e = sb_q.pop_front();
                        chk("done_err", err, e.err);
                        chk("busy_at_done", busy, 1'b0);
                        chk("aw_handshakes", aw_n, e.n_aw);
                        chk("w_handshakes", w_n, e.n_w);
                        chk("ar_handshakes", ar_n, e.n_ar);
                        if (e.rd) mdl_rdata = e.rdata;
                    end
                    aw_n = 0; w_n = 0; ar_n = 0;
                end
                chk("rdata_value", rdata, mdl_rdata);
            end
        end
    end

    // Present a request for one cycle's sampling and record its expected outcome.
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        exp_t e;
        bit   bus_wr;
        bus_wr    = w && (b != 4'h0);
        cur_addr  = a; cur_wdata = d; cur_be = b;
        e.rd      = !w;
        e.err     = w ? (bus_wr && cfg_bresp) : (cfg_rresp != 2'b00);
        e.rdata   = cfg_rdata;
        e.n_aw    = bus_wr ? 1 : 0;
        e.n_w     = bus_wr ? 1 : 0;
        e.n_ar    = w ? 0 : 1;
        sb_q.push_back(e);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (sb_q.size() == 0 && !busy) ok = 1'b1;
            else tick();
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending completions, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic cfg_clear();
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_ar_dly = 0; cfg_r_dly = 0;
        cfg_bresp = 1'b0; cfg_rresp = 2'b00;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL global_watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        bit          w;
        logic [3:0]  b;
        bit          seen;
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
        mdl_rdata = 32'h0; bus_idle_exp = 1'b0; cfg_rdata = 32'h0;
        cur_addr = 32'h0; cur_wdata = 32'h0; cur_be = 4'h0;
        cfg_clear();
        tick(); tick(); tick();

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_valids", {27'h0, bus_if.AWVALID, bus_if.WVALID, bus_if.BREADY,
                           bus_if.ARVALID, bus_if.RREADY}, 32'h0);
        chk("rst_awaddr", bus_if.AWADDR, 32'h0);
        chk("rst_wdata", bus_if.WDATA, 32'h0);
        chk("rst_wstrb", 32'(bus_if.WSTRB), 32'h0);
        chk("rst_araddr", bus_if.ARADDR, 32'h0);
        reset = 1'b0;
        tick();

        // Write with an immediately ready slave: done on cycle 3
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        tick();
        chk("w0_c1_awvalid", bus_if.AWVALID, 1'b1);
        chk("w0_c1_wvalid", bus_if.WVALID, 1'b1);
        chk("w0_c1_busy", busy, 1'b1);
        chk("w0_c1_wstrb", 32'(bus_if.WSTRB), 32'hF);
        chk("w0_c1_awaddr", bus_if.AWADDR, 32'h10);
        chk("w0_c1_wdata", bus_if.WDATA, 32'hDEADBEEF);
        req = 1'b0;
        tick();
        chk("w0_c2_bready", bus_if.BREADY, 1'b1);
        chk("w0_c2_awvalid", bus_if.AWVALID, 1'b0);
        chk("w0_c2_wvalid", bus_if.WVALID, 1'b0);
        chk("w0_c2_done", done, 1'b0);
        tick();
        chk("w0_c3_done", done, 1'b1);
        chk("w0_c3_err", err, 1'b0);
        chk("w0_c3_bready", bus_if.BREADY, 1'b0);
        wait_idle("write_fast");

        // Write with WREADY arriving three cycles after AWREADY
        cfg_w_dly = 3;
        issue(1'b1, 32'h44, 32'hCAFE0001, 4'h5);
        tick();
        chk("w1_c1_both", {30'h0, bus_if.AWVALID, bus_if.WVALID}, 32'h3);
        req = 1'b0;
        tick();
        chk("w1_c2_aw_dropped", {30'h0, bus_if.AWVALID, bus_if.WVALID}, 32'h1);
        tick();
        chk("w1_c3_wvalid", bus_if.WVALID, 1'b1);
        tick();
        chk("w1_c4_wvalid", bus_if.WVALID, 1'b1);
        chk("w1_c4_bready", bus_if.BREADY, 1'b0);
        tick();
        chk("w1_c5_bready", bus_if.BREADY, 1'b1);
        chk("w1_c5_wvalid", bus_if.WVALID, 1'b0);
        wait_idle("write_skew");
        cfg_clear();

        // Read with RVALID two cycles after AR
        cfg_r_dly = 1; cfg_rdata = 32'h12345678;
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        tick();
        chk("r0_c1_arvalid", bus_if.ARVALID, 1'b1);
        chk("r0_c1_busy", busy, 1'b1);
        req = 1'b0;
        tick();
        chk("r0_c2_rready", bus_if.RREADY, 1'b1);
        chk("r0_c2_arvalid", bus_if.ARVALID, 1'b0);
        tick();
        chk("r0_c3_done", done, 1'b0);
        tick();
        chk("r0_c4_done", done, 1'b1);
        chk("r0_c4_rdata", rdata, 32'h12345678);
        tick(); tick();
        chk("r0_rdata_held", rdata, 32'h12345678);
        wait_idle("read");
        cfg_clear();

        // Error responses
        cfg_bresp = 1'b1; cfg_b_dly = 2;
        issue(1'b1, 32'h80, 32'h0BAD0BAD, 4'h3);
        tick(); req = 1'b0;
        wait_idle("write_err");
        cfg_clear();
        cfg_rresp = 2'b10; cfg_rdata = 32'hA5A5_5A5A; cfg_ar_dly = 1;
        issue(1'b0, 32'h84, 32'h0, 4'h0);
        tick(); req = 1'b0;
        wait_idle("read_err");
        chk("read_err_rdata", rdata, 32'hA5A5_5A5A);
        cfg_clear();

        // Store with no enabled bytes
        bus_idle_exp = 1'b1;
        issue(1'b1, 32'h90, 32'h11112222, 4'h0);
        tick();
        chk("be0_c1_done", done, 1'b1);
        chk("be0_c1_err", err, 1'b0);
        chk("be0_c1_busy", busy, 1'b0);
        req = 1'b0;
        tick(); tick();
        wait_idle("be0");
        bus_idle_exp = 1'b0;

        // Back-to-back: req held through done starts the next read right after
        cfg_rdata = 32'h0F0F_1234;
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        sb_q.push_back(sb_q[sb_q.size()-1]);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("b2b_first_done", seen, 1'b1);
        tick();
        chk("b2b_second_ar", bus_if.ARVALID, 1'b1);
        chk("b2b_second_busy", busy, 1'b1);
        req = 1'b0;
        wait_idle("back_to_back");

        // Randomised transactions
        for (int n = 0; n < 40; n++) begin
            cfg_aw_dly = $urandom_range(0, 3); cfg_w_dly = $urandom_range(0, 3);
            cfg_b_dly  = $urandom_range(0, 3); cfg_ar_dly = $urandom_range(0, 3);
            cfg_r_dly  = $urandom_range(0, 3);
            cfg_bresp  = ($urandom_range(0, 3) == 0);
            cfg_rresp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cfg_rdata  = $urandom;
            w = 1'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            bus_idle_exp = w && (b == 4'h0);
            issue(w, $urandom, $urandom, b);
            tick(); req = 1'b0;
            wait_idle("random");
            bus_idle_exp = 1'b0;
        end
        cfg_clear();

        // Asynchronous reset while waiting in the read data phase
        cfg_r_dly = 20; cfg_rdata = 32'h7777_7777;
        issue(1'b0, 32'h28, 32'h0, 4'h0);
        tick(); req = 1'b0;
        tick();
        chk("rst_mid_rready_before", bus_if.RREADY, 1'b1);
        #2;
        reset = 1'b1;
        sb_q.delete();
        mdl_rdata = 32'h0;
        #1;
        chk("rst_mid_rready", bus_if.RREADY, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_mid_no_done", done, 1'b0);
        cfg_clear();

`ifdef AMBA_TIMEOUT_EN
        // Slave never accepts AR: watchdog ends the read with an error
        cfg_ar_dly = 100000;
        issue(1'b0, 32'h30, 32'h0, 4'h0);
        sb_q[sb_q.size()-1].err  = 1'b1;
        sb_q[sb_q.size()-1].rd   = 1'b0;
        sb_q[sb_q.size()-1].n_ar = 0;
        tick(); req = 1'b0;
        for (int c = 1; c <= TMO; c++) begin
            chk("tmo_waiting_arvalid", bus_if.ARVALID, 1'b1);
            chk("tmo_waiting_done", done, 1'b0);
            tick();
        end
        chk("tmo_done", done, 1'b1);
        chk("tmo_err", err, 1'b1);
        chk("tmo_arvalid", bus_if.ARVALID, 1'b0);
        wait_idle("timeout");
        cfg_clear();
`endif

        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/amba_master_bridge.md
Name: amba_master_bridge

Overview:
- AXI-lite style AMBA master port; turns a simple single-outstanding CPU load/store request into AMBA read/write channel transactions.
- Sits between the CPU core's memory stage and the AMBA bus, facing the existing memory slave and its LED/SW I/O.
- Handles one transaction at a time and returns read data plus a completion/error pulse to the CPU.

Parameters:
- ADDR_W, 32, address width on CPU side and AWADDR/ARADDR
- DATA_W, 32, data width of wdata/rdata/WDATA/RDATA
- TIMEOUT_CYCLES, 255, cycles without handshake progress before abort (used only with AMBA_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  CPU request strobe, sampled only in IDLE
- we  in  1  1=write, 0=read
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  store data
- be  in  4  byte enables for store
- busy  out  1  high whenever FSM is not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1=bus error or timeout
- rdata  out  DATA_W  load data, valid with done on reads, held until next read completes
- AWADDR  out  32  write address
- AWPROT  out  3  constant 3'b000
- AWVALID  out  1
- AWREADY  in  1
- WDATA  out  32
- WSTRB  out  4
- WVALID  out  1
- WREADY  in  1
- BVALID  in  1
- BRESP  in  1  nonzero = error (1-bit, matching the memory slave)
- BREADY  out  1
- ARADDR  out  32
- ARPROT  out  1  constant 0
- ARVALID  out  1
- ARREADY  in  1
- RVALID  in  1
- RRESP  in  2  nonzero = error
- RDATA  in  32
- RREADY  out  1

Behaviour:
- All outputs are registered.
- Reset (async, reset=1): FSM goes to IDLE. All VALID/READY outputs, busy, done and err are 0. AWADDR, WDATA, WSTRB, ARADDR and rdata are 0.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R.
- IDLE:
  - On req=1, latch addr/wdata/be.
  - If we=1 and be!=0: go to WR_AW_W; AWVALID=WVALID=1 next cycle.
  - If we=1 and be=0: no bus activity; done=1, err=0 next cycle; stay IDLE.
  - If we=0: go to RD_AR; ARVALID=1 next cycle.
- WR_AW_W:
  - AW and W are tracked independently.
  - AWVALID drops the cycle after AWVALID&AWREADY. WVALID drops the cycle after WVALID&WREADY.
  - The two handshakes may occur in the same cycle or in either order.
  - When both are complete, go to WR_B with BREADY=1.
- WR_B: on BVALID&BREADY, BREADY=0, done=1, err=|BRESP, return to IDLE.
- RD_AR: on ARVALID&ARREADY, ARVALID=0, RREADY=1, go to RD_R.
- RD_R: on RVALID&RREADY, capture rdata=RDATA, RREADY=0, done=1, err=|RRESP, return to IDLE. RDATA is captured even when err=1.
- VALID stability: once a VALID is asserted, it and its address/data stay stable until its handshake completes.
- Minimum latency:
  - Write: req at cycle 0; AW/W at cycle 1 with both ready; BREADY at cycle 2 with BVALID; done at cycle 3.
  - Read: ARVALID at cycle 1; RREADY at cycle 2; done at cycle 3.
- done is high for exactly one cycle, coincident with the return to IDLE. A req in that same cycle is accepted.
- req outside IDLE is ignored (no queueing).
- busy=1 from the cycle after req acceptance until the cycle done is asserted, inclusive of neither.
- Reset mid-transaction: all VALID/READY drop immediately (asynchronous), and no done is issued.

Optional Feature:
- Macro: AMBA_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on every state change and on every handshake, and increments in any non-IDLE state.
  - When it reaches TIMEOUT_CYCLES: drop all VALID/READY, return to IDLE, done=1, err=1. rdata is unchanged.
- Undefined: no counter is built, and the bridge waits indefinitely for the slave.

Test Plan:
- Write, slave ready immediately: req, we=1, addr=0x10, wdata=0xDEADBEEF, be=4'hF -> AW/W at cycle 1, BREADY at cycle 2, done=1/err=0 at cycle 3; WSTRB=4'hF.
- Write with skewed ready: AWREADY at cycle 1, WREADY delayed to cycle 4 -> AWVALID low from cycle 2; WVALID held with WDATA stable until cycle 4; BREADY from cycle 5.
- Read: req, we=0, addr=0x20, slave RDATA=0x12345678, RRESP=0, RVALID 2 cycles after AR -> rdata=0x12345678, done/err=1/0; rdata holds after done.
- Error responses: BRESP=1 on write -> err=1. RRESP=2'b10 on read -> err=1 and RDATA still captured.
- Edge cases:
  - be=0 write: done next cycle, no VALID ever asserted.
  - Back-to-back: req held high through done -> second transaction starts the cycle after done.
- Async reset asserted during RD_R -> RREADY/busy=0 immediately, no done. With AMBA_TIMEOUT_EN and TIMEOUT_CYCLES=8, ARREADY never asserted -> done=1, err=1 after 8 cycles in RD_AR.
